// File: rtl/crctab_arbiter_if.sv
// Shared CRC-table port bundle: per-requester lookup handshake, table address/data, one-hot response.
interface crctab_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 8
);
  logic [NREQ-1:0]             req_valid;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]             req_ready;
  logic [31:0]                 tab_addr;
  logic [31:0]                 tab_rdata;
  logic [NREQ-1:0]             rsp_valid;
  logic [31:0]                 rsp_data;

  modport master (
    output req_valid, req_addr, tab_rdata,
    input  req_ready, tab_addr, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, tab_rdata,
    output req_ready, tab_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/crctab_arbiter.sv
// Round-robin sharing of one 256x32 CRC table read port among NREQ requesters, 2-cycle response.
// Optional per-requester grant counters are enabled with `define CRCTAB_ARB_STATS_EN.
`ifdef CRCTAB_ARB_STATS_EN
module crctab_arbiter_statcnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] cnt
);
  // Clear has priority over a same-cycle grant; the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr)                 cnt <= '0;
    else if (inc && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
endmodule
`endif

module crctab_arbiter #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 8
) (
  input logic              clk,
  input logic              rst,
  crctab_arbiter_if.slave  bus
`ifdef CRCTAB_ARB_STATS_EN
  ,
  input  logic [2:0]       stat_sel,
  input  logic             stat_clr,
  output logic [15:0]      stat_cnt
`endif
);
  localparam int PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int STAGES = 2;

  logic [PW-1:0]             rr_ptr, gid, idx;
  logic                      found, accept;
  logic [NREQ-1:0]           grant;
  logic [STAGES:1]           vld_pipe;
  logic [STAGES:1][PW-1:0]   id_pipe;
  logic [ADDR_W-1:0]         addr_q;
  logic [31:0]               data_q;

  // First asserted request scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    gid   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gid   = idx;
      end
    end
  end

  assign accept        = found & ~rst;
  assign grant         = accept ? (NREQ'(1) << gid) : '0;
  assign bus.req_ready = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], accept};
      id_pipe[1] <= gid;
      id_pipe[2] <= id_pipe[1];
      if (accept) begin
        rr_ptr <= (gid == PW'(NREQ - 1)) ? '0 : gid + PW'(1);
        addr_q <= bus.req_addr[gid];
      end
      // Table is combinational off addr_q; capture only when stage 1 holds a live lookup.
      if (vld_pipe[1]) data_q <= bus.tab_rdata;
    end
  end

  // A reset cycle suppresses the pulse of a lookup already sitting in stage 2.
  assign bus.rsp_valid = (vld_pipe[STAGES] && !rst) ? (NREQ'(1) << id_pipe[STAGES]) : '0;
  assign bus.rsp_data  = data_q;
  assign bus.tab_addr  = {{(32 - ADDR_W){1'b0}}, addr_q};

`ifdef CRCTAB_ARB_STATS_EN
  logic [NREQ-1:0][15:0] cnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_stat
    crctab_arbiter_statcnt u_cnt (
      .clk (clk),
      .rst (rst),
      .clr (stat_clr),
      .inc (grant[i]),
      .cnt (cnt[i])
    );
  end

  assign stat_cnt = (int'(stat_sel) < NREQ) ? cnt[PW'(stat_sel)] : '0;
`endif
endmodule
